// File: rtl/reg_rename_file_pkg.sv
// Shared widths for the rename file, ROB and RS, plus the source-lookup result type.
package reg_rename_file_pkg;

  localparam int unsigned RREN_XLEN     = 32;
  localparam int unsigned RREN_NUM_REGS = 32;
  localparam int unsigned RREN_TAG_W    = 4;

  // Where a source operand comes from in the dispatch cycle.
  typedef enum logic [1:0] {
    SRC_ZERO    = 2'd0,  // hardwired zero register
    SRC_BYPASS  = 2'd1,  // producer retiring this very cycle
    SRC_PENDING = 2'd2,  // producer still in flight, hand out its tag
    SRC_REG     = 2'd3   // architectural value is current
  } src_sel_e;

endpackage

// File: rtl/reg_rename_file_status.sv
// Rename-status table: per-register busy bit and producer ROB tag,
// commit-clear, rename, flush, and the commit->dispatch bypass compare.
module rename_status_table
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = RREN_NUM_REGS,
  parameter int unsigned TAG_W    = RREN_TAG_W,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned RIDX_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              commit_valid,
  input  logic [RIDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              ren_valid,
  input  logic [RIDX_W-1:0] ren_rd,
  input  logic [TAG_W-1:0]  ren_tag,
  input  logic [RIDX_W-1:0] rs1,
  input  logic [RIDX_W-1:0] rs2,
  output src_sel_e          rs1_sel,
  output logic [TAG_W-1:0]  rs1_tag,
  output src_sel_e          rs2_sel,
  output logic [TAG_W-1:0]  rs2_tag
);

  logic [NUM_REGS-1:0] busy_q;
  logic [TAG_W-1:0]    tag_q [NUM_REGS];

  logic commit_hit;
  logic ren_ok;

  assign commit_hit = commit_valid && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);
  assign ren_ok     = ren_valid && !(ZERO_REG && (ren_rd == '0));

  // Classify a source against the pre-update table state.
  function automatic src_sel_e lookup(input logic [RIDX_W-1:0] idx);
    if (ZERO_REG && (idx == '0))
      return SRC_ZERO;
    if (busy_q[idx]) begin
      if (commit_valid && (commit_rd == idx) && (tag_q[idx] == commit_tag))
        return SRC_BYPASS;
      return SRC_PENDING;
    end
    return SRC_REG;
  endfunction

  // Source classification and producer tags for the dispatching instruction.
  always_comb begin
    rs1_sel = lookup(rs1);
    rs2_sel = lookup(rs2);
    rs1_tag = (rs1_sel == SRC_PENDING) ? tag_q[rs1] : '0;
    rs2_tag = (rs2_sel == SRC_PENDING) ? tag_q[rs2] : '0;
  end

  // Busy/tag update: commit clear, then rename (overrides the clear), then flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else if (en) begin
      if (commit_hit)
        busy_q[commit_rd] <= 1'b0;
      if (ren_ok) begin
        busy_q[ren_rd] <= 1'b1;
        tag_q[ren_rd]  <= ren_tag;
      end
      if (flush)
        busy_q <= '0;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename status for the Tomasulo core:
// dispatch-side operand lookup/rename and commit-side write-back.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN     = RREN_XLEN,
  parameter int unsigned NUM_REGS = RREN_NUM_REGS,
  parameter int unsigned TAG_W    = RREN_TAG_W,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned RIDX_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [RIDX_W-1:0] disp_rs1,
  input  logic [RIDX_W-1:0] disp_rs2,
  input  logic [RIDX_W-1:0] disp_rd,
  input  logic              disp_rd_we,
  input  logic [TAG_W-1:0]  disp_tag,
  output logic              out_valid,
  output logic              rs1_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [XLEN-1:0]   rs1_val,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic [XLEN-1:0]   rs2_val,
  input  logic              commit_valid,
  input  logic [RIDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [XLEN-1:0]   commit_val
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic             accept;
  logic             commit_we;
  src_sel_e         rs1_sel;
  src_sel_e         rs2_sel;
  logic [TAG_W-1:0] rs1_tag_d;
  logic [TAG_W-1:0] rs2_tag_d;
  logic             rs1_busy_d;
  logic             rs2_busy_d;
  logic [XLEN-1:0]  rs1_val_d;
  logic [XLEN-1:0]  rs2_val_d;

  assign disp_ready = rst & rdy & ~flush;
  assign accept     = disp_valid & disp_ready;
  assign commit_we  = commit_valid && !(ZERO_REG && (commit_rd == '0));

  rename_status_table #(
    .NUM_REGS (NUM_REGS),
    .TAG_W    (TAG_W),
    .ZERO_REG (ZERO_REG)
  ) u_status (
    .clk          (clk),
    .rst          (rst),
    .en           (rdy),
    .flush        (flush),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .ren_valid    (accept & disp_rd_we),
    .ren_rd       (disp_rd),
    .ren_tag      (disp_tag),
    .rs1          (disp_rs1),
    .rs2          (disp_rs2),
    .rs1_sel      (rs1_sel),
    .rs1_tag      (rs1_tag_d),
    .rs2_sel      (rs2_sel),
    .rs2_tag      (rs2_tag_d)
  );

  // Operand value for a classified source.
  function automatic logic [XLEN-1:0] operand(input src_sel_e sel, input logic [RIDX_W-1:0] idx);
    case (sel)
      SRC_BYPASS: return commit_val;
      SRC_REG:    return regs_q[idx];
      default:    return '0;
    endcase
  endfunction

  // Next operand bundle from the lookup result.
  always_comb begin
    rs1_busy_d = (rs1_sel == SRC_PENDING);
    rs2_busy_d = (rs2_sel == SRC_PENDING);
    rs1_val_d  = operand(rs1_sel, disp_rs1);
    rs2_val_d  = operand(rs2_sel, disp_rs2);
  end

  // Commit write-back; proceeds even under flush, stale tags still write.
  always_ff @(posedge clk) begin
    if (!rst)
      regs_q <= '{default: '0};
    else if (rdy && commit_we)
      regs_q[commit_rd] <= commit_val;
  end

  // Operand output registers: one-cycle valid pulse, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      rs1_busy  <= 1'b0;
      rs1_tag   <= '0;
      rs1_val   <= '0;
      rs2_busy  <= 1'b0;
      rs2_tag   <= '0;
      rs2_val   <= '0;
    end else if (rdy) begin
      out_valid <= accept;
      if (accept) begin
        rs1_busy <= rs1_busy_d;
        rs1_tag  <= rs1_tag_d;
        rs1_val  <= rs1_val_d;
        rs2_busy <= rs2_busy_d;
        rs2_tag  <= rs2_tag_d;
        rs2_val  <= rs2_val_d;
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: expected operand bundles are queued
// as dispatches are driven and compared when out_valid is produced.
module tb_reg_rename_file;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned RIDX_W   = 5;

  logic              clk = 1'b0;
  logic              rst, rdy, flush;
  logic              disp_valid, disp_ready, disp_rd_we;
  logic [RIDX_W-1:0] disp_rs1, disp_rs2, disp_rd;
  logic [TAG_W-1:0]  disp_tag;
  logic              out_valid, rs1_busy, rs2_busy;
  logic [TAG_W-1:0]  rs1_tag, rs2_tag;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              commit_valid;
  logic [RIDX_W-1:0] commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic [XLEN-1:0]   commit_val;

  always #5 clk = ~clk;

  reg_rename_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .TAG_W    (TAG_W),
    .ZERO_REG (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_rs1     (disp_rs1),
    .disp_rs2     (disp_rs2),
    .disp_rd      (disp_rd),
    .disp_rd_we   (disp_rd_we),
    .disp_tag     (disp_tag),
    .out_valid    (out_valid),
    .rs1_busy     (rs1_busy),
    .rs1_tag      (rs1_tag),
    .rs1_val      (rs1_val),
    .rs2_busy     (rs2_busy),
    .rs2_tag      (rs2_tag),
    .rs2_val      (rs2_val),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_val   (commit_val)
  );

  typedef struct {
    logic             b1;
    logic [TAG_W-1:0] t1;
    logic [XLEN-1:0]  v1;
    logic             b2;
    logic [TAG_W-1:0] t2;
    logic [XLEN-1:0]  v2;
  } exp_t;

  exp_t            sb[$];
  int              errors = 0;
  int              checks = 0;
  string           lbl = "";
  logic [XLEN-1:0] gv [NUM_REGS];

  function automatic exp_t mk(input logic b1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                              input logic b2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
    exp_t e;
    e.b1 = b1; e.t1 = t1; e.v1 = v1;
    e.b2 = b2; e.t2 = t2; e.v2 = v2;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", lbl, tag, obs, exp);
    end
  endtask

  // Advance one clock; acc says whether a dispatch was accepted at this edge.
  task automatic tick(input bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, acc});
    if (acc && sb.size() > 0) begin
      e = sb.pop_front();
      check("rs1_busy", {31'b0, rs1_busy}, {31'b0, e.b1});
      if (e.b1) check("rs1_tag", {28'b0, rs1_tag}, {28'b0, e.t1});
      else      check("rs1_val", rs1_val, e.v1);
      check("rs2_busy", {31'b0, rs2_busy}, {31'b0, e.b2});
      if (e.b2) check("rs2_tag", {28'b0, rs2_tag}, {28'b0, e.t2});
      else      check("rs2_val", rs2_val, e.v2);
    end
  endtask

  task automatic set_commit(input logic [RIDX_W-1:0] rd, input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] val);
    commit_valid = 1'b1;
    commit_rd    = rd;
    commit_tag   = tg;
    commit_val   = val;
    if (rd != '0) gv[rd] = val;
  endtask

  task automatic do_commit(input string name, input logic [RIDX_W-1:0] rd, input logic [TAG_W-1:0] tg,
                           input logic [XLEN-1:0] val);
    lbl = name;
    set_commit(rd, tg, val);
    tick(1'b0);
    commit_valid = 1'b0;
  endtask

  task automatic disp(input string name, input logic [RIDX_W-1:0] rs1, input logic [RIDX_W-1:0] rs2,
                      input logic [RIDX_W-1:0] rd, input logic we, input logic [TAG_W-1:0] tg, input exp_t e);
    lbl          = name;
    disp_valid   = 1'b1;
    disp_rs1     = rs1;
    disp_rs2     = rs2;
    disp_rd      = rd;
    disp_rd_we   = we;
    disp_tag     = tg;
    sb.push_back(e);
    tick(1'b1);
    disp_valid   = 1'b0;
    disp_rd_we   = 1'b0;
    commit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b1; disp_rs1 = 5'd5; disp_rs2 = '0; disp_rd = 5'd5; disp_rd_we = 1'b1; disp_tag = 4'd1;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_val = '0;
    for (int i = 0; i < NUM_REGS; i++) gv[i] = '0;

    // Reset held for two cycles with a dispatch attempt that must be refused.
    lbl = "reset";
    tick(1'b0);
    tick(1'b0);
    check("disp_ready", {31'b0, disp_ready}, 32'd0);
    check("rs1_busy", {31'b0, rs1_busy}, 32'd0);
    check("rs1_tag", {28'b0, rs1_tag}, 32'd0);
    check("rs1_val", rs1_val, 32'd0);
    check("rs2_val", rs2_val, 32'd0);
    disp_valid = 1'b0; disp_rd_we = 1'b0;
    rst = 1'b1;
    #1;
    check("disp_ready_after", {31'b0, disp_ready}, 32'd1);
    disp("rst_lookup", 5'd5, 5'd0, 5'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 0, 0));

    // Rename then busy lookup, commit, value lookup.
    disp("ren5", 5'd0, 5'd0, 5'd5, 1'b1, 4'd3, mk(0, 0, 0, 0, 0, 0));
    disp("busy5", 5'd5, 5'd0, 5'd0, 1'b0, 4'd0, mk(1, 3, 0, 0, 0, 0));
    do_commit("com5", 5'd5, 4'd3, 32'h1234);
    disp("val5", 5'd5, 5'd0, 5'd0, 1'b0, 4'd0, mk(0, 0, 32'h1234, 0, 0, 0));

    // Stale commit keeps the newer rename.
    disp("ren7a", 5'd0, 5'd0, 5'd7, 1'b1, 4'd2, mk(0, 0, 0, 0, 0, 0));
    disp("ren7b", 5'd0, 5'd0, 5'd7, 1'b1, 4'd6, mk(0, 0, 0, 0, 0, 0));
    do_commit("stale7", 5'd7, 4'd2, 32'd9);
    disp("busy7", 5'd7, 5'd0, 5'd0, 1'b0, 4'd0, mk(1, 6, 0, 0, 0, 0));
    do_commit("com7", 5'd7, 4'd6, 32'd11);
    disp("val7", 5'd7, 5'd0, 5'd0, 1'b0, 4'd0, mk(0, 0, 32'd11, 0, 0, 0));

    // Same-cycle commit bypass onto rs2.
    disp("ren4", 5'd0, 5'd0, 5'd4, 1'b1, 4'd1, mk(0, 0, 0, 0, 0, 0));
    set_commit(5'd4, 4'd1, 32'hAA);
    disp("bypass4", 5'd0, 5'd4, 5'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 0, 32'hAA));
    disp("after4", 5'd0, 5'd4, 5'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 0, 32'hAA));

    // Same-cycle rename beats the commit clear; source sees pre-rename mapping.
    disp("ren8", 5'd0, 5'd0, 5'd8, 1'b1, 4'd0, mk(0, 0, 0, 0, 0, 0));
    set_commit(5'd8, 4'd0, 32'd5);
    disp("ren8_vs_clr", 5'd8, 5'd0, 5'd8, 1'b1, 4'd9, mk(0, 0, 32'd5, 0, 0, 0));
    disp("rs1_eq_rd", 5'd8, 5'd0, 5'd8, 1'b1, 4'd10, mk(1, 9, 0, 0, 0, 0));
    disp("busy8", 5'd8, 5'd8, 5'd0, 1'b0, 4'd0, mk(1, 10, 0, 1, 10, 0));
    do_commit("com8", 5'd8, 4'd10, 32'h55);
    disp("val8", 5'd8, 5'd0, 5'd0, 1'b0, 4'd0, mk(0, 0, 32'h55, 0, 0, 0));

    // Rename every register, then flush alongside a commit.
    for (int r = 1; r < NUM_REGS; r++)
      disp("ren_all", 5'd0, 5'd0, 5'(r), 1'b1, 4'(r), mk(0, 0, 0, 0, 0, 0));
    disp("busy_x3", 5'd3, 5'd31, 5'd0, 1'b0, 4'd0, mk(1, 3, 0, 1, 15, 0));
    lbl = "flush";
    flush = 1'b1;
    disp_valid = 1'b1; disp_rd = 5'd12; disp_rd_we = 1'b1; disp_tag = 4'd1;
    set_commit(5'd3, 4'd0, 32'd7);
    #1;
    check("disp_ready", {31'b0, disp_ready}, 32'd0);
    tick(1'b0);
    flush = 1'b0; disp_valid = 1'b0; disp_rd_we = 1'b0; commit_valid = 1'b0;
    for (int r = 1; r < NUM_REGS; r++)
      disp("post_flush", 5'(r), 5'(r), 5'd0, 1'b0, 4'd0, mk(0, 0, gv[r], 0, 0, gv[r]));

    // Register zero: never renamed, never written.
    set_commit(5'd0, 4'd0, 32'hFF);
    disp("zero_ren", 5'd0, 5'd0, 5'd0, 1'b1, 4'd5, mk(0, 0, 0, 0, 0, 0));
    disp("zero_read", 5'd0, 5'd0, 5'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 0, 0));

    // Stall: state and outputs frozen, dispatch and commit ignored.
    disp("pre_stall", 5'd5, 5'd0, 5'd9, 1'b1, 4'd3, mk(0, 0, 32'h1234, 0, 0, 0));
    lbl = "stall";
    rdy = 1'b0;
    disp_valid = 1'b1; disp_rs1 = 5'd9; disp_rs2 = 5'd9; disp_rd = 5'd9; disp_rd_we = 1'b1; disp_tag = 4'd7;
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd0; commit_val = 32'hBEEF;
    #1;
    check("disp_ready", {31'b0, disp_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("out_valid_hold", {31'b0, out_valid}, 32'd1);
      check("rs1_busy_hold", {31'b0, rs1_busy}, 32'd0);
      check("rs1_val_hold", rs1_val, 32'h1234);
    end
    rdy = 1'b1; disp_valid = 1'b0; disp_rd_we = 1'b0; commit_valid = 1'b0;
    disp("post_stall", 5'd5, 5'd9, 5'd0, 1'b0, 4'd0, mk(0, 0, 32'h1234, 1, 3, 0));
    lbl = "idle";
    tick(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
